mips_instr_packer: RTL and testbench
====================================

# mips_instr_packer

Assembles MIPS32 instruction words from separate fields (opcode, rs, rt, rd, shamt, funct, immediate, jump target), which is the inverse of the field-split stage in the decode path. Packed words pass through a small FIFO with valid/ready handshakes on both sides. Each word is tagged with an incrementing load address. The block sits between the program loader / test stimulus and the instruction-memory write port.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_W, 8: width of the load-address tag.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of FIFO and address counter.
- in_valid  in  1  field set present.
- in_ready  out  1  packer can accept this cycle.
- fmt  in  2  00=R, 01=I, 10=J, 11=illegal.
- opcode  in  6; rs, rt, rd, shamt  in  5 each; funct  in  6; imm  in  16; target  in  26  instruction fields.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes head word.
- out_instr  out  32  packed head word.
- out_addr  out  ADDR_W  load address of head word.
- count  out  $clog2(DEPTH)+1  current occupancy.
- err  out  1  illegal-format pulse (see Configuration).

## Operation
- Packing:
  - R: {opcode,rs,rt,rd,shamt,funct}.
  - I: {opcode,rs,rt,imm}.
  - J: {opcode,target}.
  - Fields unused by the selected format are ignored.
- Push occurs when in_valid && in_ready. The entry stores the packed word and the current wr_addr counter value. wr_addr then increments modulo 2^ADDR_W (255 wraps to 0 at the default width).
- in_ready = !full. There is no bypass: when full, in_ready is low even if a pop happens in the same cycle.
- Pop occurs when out_valid && out_ready. out_valid = !empty.
- When out_valid is low, out_instr and out_addr read 0.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- clear has priority over push and pop in the same cycle. It empties the FIFO, zeroes count and wr_addr, drops any word offered that cycle, and holds in_ready low during the clear cycle.
- Reset values: out_valid=0, in_ready=1 after reset deasserts, out_instr=0, out_addr=0, count=0, err=0, wr_addr=0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Timing
- Latency: a word pushed in cycle N is visible on out_valid/out_instr in cycle N+1 at the earliest.
- in_ready, out_valid and count are registered-state functions with no combinational path from in_valid or out_ready.
- Sustained throughput is one word per cycle when the consumer holds out_ready high.
- out_instr/out_addr stay stable while out_valid && !out_ready.
- err is a single-cycle pulse in the cycle after the offending handshake.

## Configuration
- Macro: PACKER_FMT_CHECK_EN.
- Defined: fmt=11 with in_valid && in_ready consumes the input but writes nothing. wr_addr does not advance and err pulses high for one cycle.
- Undefined: fmt=11 packs as R-type and is pushed normally; err is tied to 0.

## Test plan
- Reset, then push R fields (opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20) -> next cycle out_valid=1, out_instr=0x00221820, out_addr=0.
- Push I (opcode=0x08, rs=1, rt=2, imm=0xFFFF), then J (opcode=0x02, target=0x0000100), with out_ready=1 -> words 0x2022FFFF at addr 0, then 0x08000100 at addr 1, on consecutive cycles.
- Hold out_ready=0 and push DEPTH words -> count=DEPTH, in_ready=0. Raise out_ready while in_valid is high -> exactly one pop and no push that cycle; in_ready returns to 1 the next cycle; data order preserved.
- Push 257 words with ADDR_W=8 -> out_addr sequence 0..255 then 0.
- Assert clear with 3 entries queued and in_valid high -> next cycle count=0, out_valid=0, next accepted word tagged addr 0. Assert rst_n=0 mid-stream -> outputs go to reset values immediately.
- fmt=11 push:
  - With PACKER_FMT_CHECK_EN: err=1 for one cycle, count unchanged, address not consumed.
  - Without: word is pushed as R-type and err stays 0.

Source files
------------

// File: rtl/mips_instr_packer.sv
// mips_instr_packer
//
// Builds MIPS32 instruction words from separate fields. This is the inverse of
// the field split in the decode path. Packed words are queued in a small FIFO
// with valid/ready handshakes on both sides. Each word carries an incrementing
// load address for the instruction-memory write port.
//
// Optional feature macro: PACKER_FMT_CHECK_EN
//   defined   : fmt=11 handshakes are consumed without writing an entry, the
//               load address does not advance, and err pulses for one cycle.
//   undefined : fmt=11 is packed as R-type and pushed normally; err is tied 0.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  width of the load-address tag
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of FIFO and address counter
//   in_valid   field set present
//   in_ready   packer can accept this cycle
//   fmt        00=R, 01=I, 10=J, 11=illegal
//   opcode, rs, rt, rd, shamt, funct, imm, target   instruction fields
//   out_valid  head word available
//   out_ready  consumer takes head word
//   out_instr  packed head word (0 when out_valid is low)
//   out_addr   load address of head word (0 when out_valid is low)
//   count      current occupancy
//   err        illegal-format pulse, one cycle after the offending handshake
module mips_instr_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 fmt,
    input  logic [5:0]                 opcode,
    input  logic [4:0]                 rs,
    input  logic [4:0]                 rt,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 shamt,
    input  logic [5:0]                 funct,
    input  logic [15:0]                imm,
    input  logic [25:0]                target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic [ADDR_W-1:0] wr_addr;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];

    logic full;
    logic empty;
    logic accept;
    logic fmt_bad;
    logic push;
    logic pop;

    function automatic logic [31:0] pack_word(
        input logic [1:0]  f,
        input logic [5:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        case (f)
            2'b01:   w = {op, f_rs, f_rt, f_imm};
            2'b10:   w = {op, f_target};
            // R-type, and also the illegal code when it is allowed through
            default: w = {op, f_rs, f_rt, f_rd, f_shamt, f_funct};
        endcase
        return w;
    endfunction

    assign full  = (occ == FULL_CNT);
    assign empty = (occ == '0);

    // No bypass: a pop in the same cycle does not reopen a full FIFO.
    // clear closes the input so the word offered during a flush is dropped.
    assign in_ready  = !full && !clear;
    assign out_valid = !empty;
    assign count     = occ;

    assign accept = in_valid && in_ready;

`ifdef PACKER_FMT_CHECK_EN
    assign fmt_bad = (fmt == 2'b11);
`else
    assign fmt_bad = 1'b0;
`endif

    assign push = accept && !fmt_bad;
    assign pop  = out_valid && out_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            wr_addr <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            wr_addr <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                wr_addr <= wr_addr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through occ.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= pack_word(fmt, opcode, rs, rt, rd, shamt,
                                           funct, imm, target);
            addr_mem[wr_ptr]  <= wr_addr;
        end
    end

    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_addr  = out_valid ? addr_mem[rd_ptr]  : '0;

`ifdef PACKER_FMT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && fmt_bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_instr_packer.sv
// Testbench for mips_instr_packer: scoreboard of expected (word, address)
// pairs filled on accepted pushes and drained on DUT pops, plus directed
// checks of reset, full, address wrap, clear, async reset and fmt=11.
module tb_mips_instr_packer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [CW-1:0]     count;
    logic              err;

    mips_instr_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference packing written bit-field by bit-field
    function automatic logic [31:0] model_pack(
        input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
        input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        logic [31:0] w;
        w = 32'h0;
        w[31:26] = op;
        if (f == 2'b01) begin
            w[25:21] = a; w[20:16] = b; w[15:0] = im;
        end else if (f == 2'b10) begin
            w[25:0] = tg;
        end else begin
            w[25:21] = a; w[20:16] = b; w[15:11] = c; w[10:6] = d; w[5:0] = fn;
        end
        return w;
    endfunction

    // Scoreboard
    logic [39:0]       exp_q[$];
    logic [39:0]       mon_e;
    logic [ADDR_W-1:0] model_addr = '0;
    logic              exp_err = 1'b0;
    logic [ADDR_W-1:0] last_pop_addr = '0;
    int                pop_total = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_addr = '0;
            exp_err    = 1'b0;
        end else begin
            check_eq("err", 32'(err), 32'(exp_err));
            exp_err = 1'b0;
            if (clear) begin
                exp_q.delete();
                model_addr = '0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("sb_instr", out_instr, mon_e[39:8]);
                        check_eq("sb_addr", 32'(out_addr), 32'(mon_e[7:0]));
                    end
                    last_pop_addr = out_addr;
                    pop_total++;
                end
                if (in_valid && in_ready) begin
`ifdef PACKER_FMT_CHECK_EN
                    if (fmt == 2'b11) begin
                        exp_err = 1'b1;
                    end else begin
                        exp_q.push_back({model_pack(fmt, opcode, rs, rt, rd, shamt,
                                                    funct, imm, target), model_addr});
                        model_addr = model_addr + 1'b1;
                    end
`else
                    exp_q.push_back({model_pack(fmt, opcode, rs, rt, rd, shamt,
                                                funct, imm, target), model_addr});
                    model_addr = model_addr + 1'b1;
`endif
                end
            end
        end
    end

    // Stimulus helpers: all called at posedge+1 and return at posedge+1
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [5:0] op,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
        input logic [4:0] d, input logic [5:0] fn, input logic [15:0] im,
        input logic [25:0] tg);
        fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = d;
        funct = fn; imm = im; target = tg;
    endtask

    task automatic set_rand_fields();
        set_fields(2'($urandom_range(0, 2)), 6'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                   16'($urandom), 26'($urandom));
    endtask

    task automatic drive_cur();
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check_eq("drive_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drive_rand();
        set_rand_fields();
        drive_cur();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        if (out_valid) check_eq("drain_timeout", 32'(out_valid), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    int pops_before;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(2'b00, '0, '0, '0, '0, '0, '0, '0, '0);

        // Reset values
        do_reset();
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_addr", 32'(out_addr), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // R-type word
        set_fields(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        drive_cur();
        @(negedge clk);
        check_eq("r_valid", 32'(out_valid), 32'd1);
        check_eq("r_instr", out_instr, 32'h00221820);
        check_eq("r_addr", 32'(out_addr), 32'd0);
        check_eq("r_count", 32'(count), 32'd1);
        @(posedge clk); #1;
        drain();

        // I then J, output on consecutive cycles
        do_reset();
        set_fields(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0);
        drive_cur();
        set_fields(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000100);
        drive_cur();
        @(negedge clk);
        check_eq("ij_count", 32'(count), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("i_instr", out_instr, 32'h2022FFFF);
        check_eq("i_addr", 32'(out_addr), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("j_instr", out_instr, 32'h08000100);
        check_eq("j_addr", 32'(out_addr), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("ij_empty", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Full FIFO, pop without push in the same cycle
        do_reset();
        repeat (DEPTH) drive_rand();
        @(negedge clk);
        check_eq("full_count", 32'(count), DEPTH);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        set_rand_fields();
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("full_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("after_pop_count", 32'(count), DEPTH - 1);
        check_eq("after_pop_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("refill_count", 32'(count), DEPTH);
        @(posedge clk); #1;
        drain();

        // Address wrap over 257 words
        do_reset();
        out_ready = 1'b1;
        pops_before = pop_total;
        repeat (257) drive_rand();
        drain();
        check_eq("wrap_pops", 32'(pop_total - pops_before), 32'd257);
        check_eq("wrap_last_addr", 32'(last_pop_addr), 32'd0);

        // clear with entries queued and input offered
        do_reset();
        repeat (3) drive_rand();
        set_rand_fields();
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        check_eq("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("clear_count", 32'(count), 32'd0);
        check_eq("clear_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        drive_rand();
        @(negedge clk);
        check_eq("clear_next_valid", 32'(out_valid), 32'd1);
        check_eq("clear_next_addr", 32'(out_addr), 32'd0);
        @(posedge clk); #1;
        drain();

        // Asynchronous reset mid-stream
        drive_rand();
        drive_rand();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_out_instr", out_instr, 32'd0);
        check_eq("arst_out_addr", 32'(out_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Illegal format
        do_reset();
        drive_rand();
        set_fields(2'b11, 6'd0, 5'd4, 5'd5, 5'd6, 5'd1, 6'h2a, 16'h1234, 26'h0);
        drive_cur();
        @(negedge clk);
`ifdef PACKER_FMT_CHECK_EN
        check_eq("bad_err", 32'(err), 32'd1);
        check_eq("bad_count", 32'(count), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("bad_err_pulse", 32'(err), 32'd0);
        @(posedge clk); #1;
        drive_rand();
        @(negedge clk);
        check_eq("bad_next_count", 32'(count), 32'd2);
`else
        check_eq("bad_err", 32'(err), 32'd0);
        check_eq("bad_count", 32'(count), 32'd2);
`endif
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
